// File: rtl/lcd_timing_monitor.sv
// lcd_timing_monitor
// Sink-side monitor for an LCD_HS/LCD_VS/LCD_DE/RGB pixel stream. It measures
// the frame geometry (line period, DE pixels per line, lines per frame, active
// lines per frame), declares lock after two identical consecutive frames, and
// flags any later deviation. It also re-emits each pixel with its coordinates
// and a per-frame RGB checksum.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   pix_ce                pixel clock enable; inputs sampled / counters advance only when 1
//   LCD_HS/LCD_VS/LCD_DE  sync and data-enable inputs (sync polarity set by SYNC_POL)
//   R, G, B               8-bit colour inputs
//   h_total, h_active     published line period and DE pixels per active line
//   v_total, v_active     published lines per frame and active lines per frame
//   frame_sum             sum mod 2^24 of {R,G,B} over the DE pixels of the published frame
//   frame_done            one-cycle pulse when the measurement outputs update
//   locked                geometry stable
//   timing_err            one-cycle pulse on a geometry mismatch while locked
//   de_err                sticky: an active line's DE count differed from the frame's first
//   pix_valid, pix_rgb    registered DE / {R,G,B}
//   pix_x, pix_y          DE index in the line, active-line index in the frame
//
// Pixel output semantics: pix_valid qualifies pix_x/pix_y/pix_rgb. There is no
// back-pressure; a new pixel is presented only on a cycle with pix_ce=1, and the
// outputs hold their value while pix_ce=0.
module lcd_timing_monitor #(
  parameter int   CNT_W    = 12,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  input  logic             LCD_HS,
  input  logic             LCD_VS,
  input  logic             LCD_DE,
  input  logic [7:0]       R,
  input  logic [7:0]       G,
  input  logic [7:0]       B,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic [23:0]      frame_sum,
  output logic             frame_done,
  output logic             locked,
  output logic             timing_err,
  output logic             de_err,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [23:0]      pix_rgb
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQ     = 2'd1;
  localparam logic [1:0] ST_CONFIRM = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  // Input pipeline
  logic        hs1_q, vs1_q, de1_q, hs2_q, vs2_q;
  logic [23:0] rgb1_q;

  // Measurement state
  logic [CNT_W-1:0] hcnt_q, decnt_q, lcnt_q, alcnt_q, period_q, ref_q, xidx_q;
  logic             ref_vld_q, sat_q, vs_pend_q;
  logic [23:0]      sum_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] st_htot_q, st_hact_q, st_vtot_q, st_vact_q;

  // Output registers
  logic [CNT_W-1:0] h_total_q, h_active_q, v_total_q, v_active_q, pix_x_q, pix_y_q;
  logic [23:0]      frame_sum_q, pix_rgb_q;
  logic             frame_done_q, locked_q, timing_err_q, de_err_q, pix_valid_q;

  // Edge detection on stage1 vs stage2; gated by pix_ce so that a frozen
  // pipeline cannot report the same edge twice.
  logic hs_start, vs_start;
  assign hs_start = pix_ce && (hs1_q == SYNC_POL) && (hs2_q != SYNC_POL);
  assign vs_start = pix_ce && (vs1_q == SYNC_POL) && (vs2_q != SYNC_POL);

  // Values after this cycle's hs_start is applied; vs_start sees these, so a
  // line ending together with the frame is counted in the finishing frame.
  logic             line_act, hcnt_full, first_act, de_mis, sat_now, frame_sat, geom_ok;
  logic [CNT_W-1:0] period_d, lcnt_d, alcnt_d, ref_d, x_base;
  logic             locked_d, publish, store, terr_set;

  always_comb begin
    line_act  = (decnt_q != '0);
    hcnt_full = (hcnt_q == CNT_MAX);
    period_d  = hs_start ? (hcnt_full ? CNT_MAX : hcnt_q + ONE) : period_q;
    lcnt_d    = hs_start ? sat_inc(lcnt_q) : lcnt_q;
    alcnt_d   = (hs_start && line_act) ? sat_inc(alcnt_q) : alcnt_q;
    first_act = hs_start && line_act && !ref_vld_q;
    ref_d     = first_act ? decnt_q : ref_q;
    de_mis    = hs_start && line_act && ref_vld_q && (decnt_q != ref_q);
    x_base    = hs_start ? '0 : xidx_q;
    // Any counter pinned at its maximum while it should advance poisons the frame.
    sat_now   = pix_ce && (hcnt_full
                || (de1_q && !hs_start && (decnt_q == CNT_MAX))
                || (hs_start && (lcnt_q == CNT_MAX))
                || (hs_start && line_act && (alcnt_q == CNT_MAX)));
    frame_sat = sat_q || sat_now;
    geom_ok   = (period_d == st_htot_q) && (ref_d == st_hact_q) &&
                (lcnt_d == st_vtot_q) && (alcnt_d == st_vact_q) && !frame_sat;
  end

  // Lock FSM; it only moves on vs_start.
  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    publish  = 1'b0;
    store    = 1'b0;
    terr_set = 1'b0;
    if (vs_start) begin
      case (state_q)
        ST_SEARCH: state_d = ST_ACQ;
        ST_ACQ: begin
          publish = 1'b1;
          store   = 1'b1;
          state_d = ST_CONFIRM;
        end
        ST_CONFIRM: begin
          publish = 1'b1;
          if (geom_ok) begin
            locked_d = 1'b1;
            state_d  = ST_LOCKED;
          end else begin
            store = 1'b1;
          end
        end
        ST_LOCKED: begin
          publish = 1'b1;
          if (!geom_ok) begin
            locked_d = 1'b0;
            terr_set = 1'b1;
            store    = 1'b1;
            state_d  = ST_CONFIRM;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0; hs2_q <= 1'b0; vs2_q <= 1'b0;
      rgb1_q <= '0;
      hcnt_q <= '0; decnt_q <= '0; lcnt_q <= '0; alcnt_q <= '0; period_q <= '0;
      ref_q <= '0; xidx_q <= '0; ref_vld_q <= 1'b0; sat_q <= 1'b0; vs_pend_q <= 1'b0;
      sum_q <= '0; state_q <= ST_SEARCH;
      st_htot_q <= '0; st_hact_q <= '0; st_vtot_q <= '0; st_vact_q <= '0;
      h_total_q <= '0; h_active_q <= '0; v_total_q <= '0; v_active_q <= '0;
      pix_x_q <= '0; pix_y_q <= '0; frame_sum_q <= '0; pix_rgb_q <= '0;
      frame_done_q <= 1'b0; locked_q <= 1'b0; timing_err_q <= 1'b0;
      de_err_q <= 1'b0; pix_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      frame_done_q <= publish;
      timing_err_q <= terr_set;
      vs_pend_q    <= vs_start;
      // Clear one cycle after the frame start; a mismatch in that cycle wins.
      if (vs_pend_q) de_err_q <= 1'b0;
      if (de_mis)    de_err_q <= 1'b1;

      if (publish) begin
        h_total_q   <= period_d;
        h_active_q  <= ref_d;
        v_total_q   <= lcnt_d;
        v_active_q  <= alcnt_d;
        frame_sum_q <= sum_q;
      end
      if (store) begin
        st_htot_q <= period_d;
        st_hact_q <= ref_d;
        st_vtot_q <= lcnt_d;
        st_vact_q <= alcnt_d;
      end

      if (pix_ce) begin
        hs1_q  <= LCD_HS;
        vs1_q  <= LCD_VS;
        de1_q  <= LCD_DE;
        rgb1_q <= {R, G, B};
        hs2_q  <= hs1_q;
        vs2_q  <= vs1_q;

        pix_valid_q <= de1_q;
        pix_rgb_q   <= rgb1_q;
        if (de1_q) begin
          pix_x_q <= x_base;
          xidx_q  <= sat_inc(x_base);
        end else begin
          xidx_q  <= x_base;
        end
        if (vs_start)                  pix_y_q <= '0;
        else if (hs_start && line_act) pix_y_q <= sat_inc(pix_y_q);

        // The pixel sampled on the hs_start cycle is the first of the new line.
        hcnt_q   <= hs_start ? '0 : (hcnt_full ? hcnt_q : hcnt_q + ONE);
        period_q <= period_d;
        if (hs_start)   decnt_q <= de1_q ? ONE : '0;
        else if (de1_q) decnt_q <= sat_inc(decnt_q);

        if (vs_start) begin
          lcnt_q    <= '0;
          alcnt_q   <= '0;
          ref_q     <= '0;
          ref_vld_q <= 1'b0;
          sat_q     <= 1'b0;
          sum_q     <= de1_q ? rgb1_q : 24'd0;
        end else begin
          lcnt_q  <= lcnt_d;
          alcnt_q <= alcnt_d;
          ref_q   <= ref_d;
          if (first_act) ref_vld_q <= 1'b1;
          sat_q   <= frame_sat;
          sum_q   <= sum_q + (de1_q ? rgb1_q : 24'd0);
        end
      end
    end
  end

  assign h_total    = h_total_q;
  assign h_active   = h_active_q;
  assign v_total    = v_total_q;
  assign v_active   = v_active_q;
  assign frame_sum  = frame_sum_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign timing_err = timing_err_q;
  assign de_err     = de_err_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;

endmodule

// File: doc/lcd_timing_monitor.md
Name: lcd_timing_monitor

Overview:
- Sink-side companion to the VGA_Basic LCD driver. Consumes the LCD_HS/LCD_VS/LCD_DE/RGB stream and measures frame geometry: total and active pixels per line, total and active lines per frame.
- Declares lock after two identical consecutive frames, then flags any deviation.
- Produces per-pixel coordinates and a per-frame RGB checksum for self-checking benches and on-board loopback.

Parameters:
- CNT_W, 12, width of all pixel/line counters and measurement outputs.
- SYNC_POL, 0, active level of LCD_HS/LCD_VS (0 = active-low, 1 = active-high).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- pix_ce  in  1  pixel clock enable; inputs are sampled and counters advance only when 1.
- LCD_HS  in  1  horizontal sync.
- LCD_VS  in  1  vertical sync.
- LCD_DE  in  1  data enable.
- R  in  8  red. G  in  8  green. B  in  8  blue.
- h_total  out  CNT_W  pixels per line, HS-start to HS-start.
- h_active  out  CNT_W  DE-high pixels per active line.
- v_total  out  CNT_W  lines per frame, VS-start to VS-start.
- v_active  out  CNT_W  lines containing at least one DE pixel.
- frame_sum  out  24  sum mod 2^24 of {R,G,B} over DE pixels of the last frame.
- frame_done  out  1  one-cycle pulse when the measurement outputs update.
- locked  out  1  geometry is stable.
- timing_err  out  1  one-cycle pulse on a geometry mismatch while locked.
- de_err  out  1  sticky; an active line's DE count differed from the frame's first active line. Cleared at the next frame start.
- pix_valid  out  1  registered DE.
- pix_x  out  CNT_W  DE index within the line.
- pix_y  out  CNT_W  active-line index within the frame.
- pix_rgb  out  24  registered {R,G,B}.

Behaviour:
- Reset: all outputs, counters, stored geometry and FSM go to 0 / SEARCH, asynchronously.
- Input stage: when pix_ce=1, HS/VS/DE/RGB are registered into stage 1, and stage 1 is copied into stage 2. pix_ce=0 freezes everything except that pulses clear.
- Sync start events:
  - hs_start = stage1 HS at active level AND stage2 HS not at active level; vs_start is defined the same way.
  - vs_start is evaluated after hs_start in the same cycle.
- Pixel path: pix_valid/pix_rgb = stage1 values (latency 2 ce-cycles from the pins). pix_x increments per valid pixel and clears at hs_start. pix_y increments at hs_start if the finished line had DE, and clears at vs_start.
- Horizontal counting:
  - hcnt clears to 0 at hs_start, otherwise increments, saturating at 2^CNT_W-1.
  - At hs_start: line period = hcnt+1. decnt (DE pixels this line) is captured, then cleared.
  - The line is active if decnt>0. The first active line's decnt is the frame reference; a later active line with a different decnt sets de_err.
- Vertical counting: lcnt increments at each hs_start. alcnt increments per active line.
- At vs_start:
  - The candidate set {h_total = last line period, h_active = reference decnt, v_total = lcnt, v_active = alcnt, frame_sum} is formed.
  - lcnt, alcnt and the sum clear. de_err clears one cycle later unless it is re-set.
- FSM, transitions on vs_start only:
  - SEARCH: first vs_start -> ACQ. No outputs update, since the first frame is partial.
  - ACQ: publish the candidate to the outputs, pulse frame_done, store it -> CONFIRM.
  - CONFIRM: publish and pulse frame_done. If candidate == stored: locked=1 -> LOCKED. Else store the candidate and stay in CONFIRM.
  - LOCKED: publish and pulse frame_done. If there is a mismatch, or a saturated counter: locked=0, timing_err pulse, store the candidate -> CONFIRM.
- frame_sum is excluded from the equality compare.
- Saturation: any counter saturating during a frame forces a mismatch at that frame's vs_start. Counters hold at max and do not wrap.
- No hs_start ever: lcnt stays 0, v_total publishes 0, and the block never locks.
- rst mid-frame: returns to SEARCH. The first partial frame is discarded.

Test Plan:
- 800x480 stream, h_total 1056, v_total 525, pix_ce=1, constant B=8'h01, R=G=0 -> after 3rd vs_start: h_total=1056, h_active=800, v_total=525, v_active=480, locked=1, frame_sum=24'h05DC00, de_err=0.
- Locked, then one frame with h_total=1057 -> at that frame's vs_start, locked falls and timing_err pulses for 1 cycle. The following identical 1057 frame relocks.
- Line 100 of a frame with DE shortened to 799 -> de_err=1 from that line's hs_start; locked unaffected; de_err clears after the next frame start.
- pix_ce toggling 1/0 every cycle with the same stream -> identical measurements; frame_done is still 1 cycle wide.
- VS held inactive, HS running for more than 4095 lines -> lcnt saturates at 4095 and no lock occurs. VS resuming -> locks after 2 good frames.
- rst asserted mid-frame while locked -> all outputs 0 immediately. After release, lock occurs at the 3rd vs_start.
